// File: rtl/dcm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dcm_ctrl_pkg
//   Shared definitions for the DCM reset/lock sequencer.
//   - dcm_state_e : sequencer states
//   - LOSS_CNT_W  : width of the saturating lock-loss counter
//   - max3()      : helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package dcm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } dcm_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single-bit asynchronous input.
//   Ports:
//     clk : destination clock
//     rst : synchronous active-high reset, clears both flops
//     d   : asynchronous input
//     q   : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples its input from before the edge; with blocking '=' here the
    // two stages would collapse into one and the metastability filter is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_reset_ctrl.sv
// -----------------------------------------------------------------------------
// dcm_reset_ctrl
//   Reset and lock sequencer for the board DCM. Pulses the DCM reset, waits
//   for CLK_VALID, requires it to stay stable before releasing the system
//   reset, re-arms the DCM on loss of lock and faults after repeated timeouts.
//   Ports:
//     CLK_IN1   : free-running primary clock (same net as the DCM input)
//     RESET     : synchronous active-high reset
//     CLK_VALID : DCM lock status, asynchronous to CLK_IN1
//     DCM_RST   : reset to the DCM (high in S_RESET and S_FAULT)
//     SYS_RST   : reset to DCM-clocked logic (low only in S_RUN)
//     LOCKED_OK : high only in S_RUN
//     FAULT     : high only in S_FAULT
//     RETRY_CNT : failed lock attempts since the last S_RUN
//     LOSS_CNT  : lock losses seen in S_RUN, saturating
// -----------------------------------------------------------------------------
module dcm_reset_ctrl
    import dcm_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               CLK_IN1,
    input  logic                               RESET,
    input  logic                               CLK_VALID,
    output logic                               DCM_RST,
    output logic                               SYS_RST,
    output logic                               LOCKED_OK,
    output logic                               FAULT,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   RETRY_CNT,
    output logic [LOSS_CNT_W-1:0]              LOSS_CNT
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    // A pulse shorter than the synchronizer depth plus margin could enter
    // S_WAIT_LOCK while valid_s still reflects the previous lock.
    if (RST_PULSE_CYCLES < 4) begin : g_bad_pulse
        $error("dcm_reset_ctrl: RST_PULSE_CYCLES must be at least 4");
    end
    if (MAX_RETRIES < 1) begin : g_bad_retries
        $error("dcm_reset_ctrl: MAX_RETRIES must be at least 1");
    end

    dcm_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
    logic                    valid_s;

    sync_2ff u_valid_sync (
        .clk (CLK_IN1),
        .rst (RESET),
        .d   (CLK_VALID),
        .q   (valid_s)
    );

    // Next-state and counter-update decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            S_RESET: begin
                if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock wins over a coincident timeout: no retry is charged.
                if (valid_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RESET;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
            end
            S_STABLE: begin
                // A drop wins over a coincident stable limit: no release.
                if (!valid_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!valid_s) begin
                    state_d = S_RESET;
                    if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State, counters and registered Moore outputs. The outputs are flopped
    // from the next-state decode so they equal a decode of state_q but cannot
    // glitch while the multi-bit state register changes.
    always_ff @(posedge CLK_IN1) begin
        if (RESET) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            DCM_RST   <= 1'b1;
            SYS_RST   <= 1'b1;
            LOCKED_OK <= 1'b0;
            FAULT     <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == S_RESET || state_q == S_WAIT_LOCK ||
                         state_q == S_STABLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            DCM_RST   <= (state_d == S_RESET) || (state_d == S_FAULT);
            SYS_RST   <= (state_d != S_RUN);
            LOCKED_OK <= (state_d == S_RUN);
            FAULT     <= (state_d == S_FAULT);
        end
    end

    assign RETRY_CNT = retry_q;
    assign LOSS_CNT  = loss_q;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcm_reset_ctrl
//   Directed bench for dcm_reset_ctrl with RST_PULSE=4, TIMEOUT=100,
//   STABLE=16, MAX_RETRIES=2. Inputs change and outputs are sampled on the
//   falling edge; 'cyc' counts rising edges since RESET was last released.
// -----------------------------------------------------------------------------
module tb_dcm_reset_ctrl;
    import dcm_ctrl_pkg::*;

    localparam int RST_PULSE   = 4;
    localparam int TIMEOUT     = 100;
    localparam int STABLE      = 16;
    localparam int MAX_RETRIES = 2;
    localparam int RETRY_W     = $clog2(MAX_RETRIES + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  clk_valid;
    logic                  dcm_rst;
    logic                  sys_rst;
    logic                  locked_ok;
    logic                  fault;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int edges;

    always #5 clk = ~clk;

    dcm_reset_ctrl #(
        .RST_PULSE_CYCLES    (RST_PULSE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .STABLE_CYCLES       (STABLE),
        .MAX_RETRIES         (MAX_RETRIES)
    ) dut (
        .CLK_IN1   (clk),
        .RESET     (reset),
        .CLK_VALID (clk_valid),
        .DCM_RST   (dcm_rst),
        .SYS_RST   (sys_rst),
        .LOCKED_OK (locked_ok),
        .FAULT     (fault),
        .RETRY_CNT (retry_cnt),
        .LOSS_CNT  (loss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dcm_rst"},   32'(dcm_rst),   32'd1);
        check({tag, "_sys_rst"},   32'(sys_rst),   32'd1);
        check({tag, "_locked_ok"}, 32'(locked_ok), 32'd0);
        check({tag, "_fault"},     32'(fault),     32'd0);
        check({tag, "_retry"},     32'(retry_cnt), 32'd0);
        check({tag, "_loss"},      32'(loss_cnt),  32'd0);
    endtask

    // One rising edge with RESET high, then release; cyc restarts at 0.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        check_reset_values(tag);
    endtask

    // Counts edges from the first one after the call until SYS_RST is seen
    // low; returns the number of edges after that first one.
    task automatic wait_release(input string tag, output int n_edges);
        int n;
        n = 0;
        while (sys_rst !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (sys_rst !== 1'b0) check({tag, "_timeout"}, 32'(sys_rst), 32'd0);
        n_edges = n - 1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulse;
        reset     = 1'b1;
        clk_valid = 1'b0;
        @(negedge clk);

        // Power-on reset, pulse width, first release.
        apply_reset("por");
        pulse = 0;
        while (dcm_rst && pulse < 50) begin
            pulse++;
            tick();
        end
        check("dcm_pulse_width", 32'(pulse), 32'd4);
        tick_to(10);
        clk_valid = 1'b1;
        wait_release("first_release", edges);
        check("first_release_edges", 32'(edges), 32'd18);
        check("first_locked_ok", 32'(locked_ok), 32'd1);
        check("first_retry", 32'(retry_cnt), 32'd0);
        check("first_dcm_rst", 32'(dcm_rst), 32'd0);

        // Loss of lock in RUN, then relock with CLK_VALID back at once.
        clk_valid = 1'b0;
        tick();
        tick();
        check("loss_sys_rst_k1", 32'(sys_rst), 32'd0);
        tick();
        check("loss_sys_rst_k2", 32'(sys_rst), 32'd1);
        check("loss_dcm_rst_k2", 32'(dcm_rst), 32'd1);
        check("loss_cnt_1", 32'(loss_cnt), 32'd1);
        clk_valid = 1'b1;
        wait_release("relock", edges);
        check("relock_edges", 32'(edges), 32'd20);
        for (int i = 2; i <= 300; i++) begin
            clk_valid = 1'b0;
            repeat (3) tick();
            clk_valid = 1'b1;
            wait_release("relock_loop", edges);
            if (i == 254) check("loss_cnt_254", 32'(loss_cnt), 32'd254);
            if (i == 255) check("loss_cnt_255", 32'(loss_cnt), 32'd255);
        end
        check("loss_cnt_sat", 32'(loss_cnt), 32'd255);
        check("loss_loop_locked", 32'(locked_ok), 32'd1);

        // Lock never arrives: three attempts, then FAULT.
        clk_valid = 1'b0;
        apply_reset("pre_retry");
        tick_to(103);
        check("to1_pre_dcm", 32'(dcm_rst), 32'd0);
        check("to1_pre_retry", 32'(retry_cnt), 32'd0);
        tick_to(104);
        check("to1_dcm", 32'(dcm_rst), 32'd1);
        check("to1_retry", 32'(retry_cnt), 32'd1);
        tick_to(107);
        check("to1_dcm_last", 32'(dcm_rst), 32'd1);
        tick_to(108);
        check("to1_dcm_end", 32'(dcm_rst), 32'd0);
        tick_to(207);
        check("to2_pre_dcm", 32'(dcm_rst), 32'd0);
        tick_to(208);
        check("to2_dcm", 32'(dcm_rst), 32'd1);
        check("to2_retry", 32'(retry_cnt), 32'd2);
        tick_to(311);
        check("to3_pre_fault", 32'(fault), 32'd0);
        check("to3_pre_dcm", 32'(dcm_rst), 32'd0);
        tick_to(312);
        check("fault", 32'(fault), 32'd1);
        check("fault_dcm_rst", 32'(dcm_rst), 32'd1);
        check("fault_sys_rst", 32'(sys_rst), 32'd1);
        check("fault_locked", 32'(locked_ok), 32'd0);
        check("fault_retry", 32'(retry_cnt), 32'd2);
        tick_to(400);
        check("fault_absorbing", 32'(fault), 32'd1);
        apply_reset("fault_exit");

        // One-cycle glitch at cnt=10 of S_STABLE with one retry on record.
        tick_to(104);
        check("glitch_retry_pre", 32'(retry_cnt), 32'd1);
        tick_to(120);
        clk_valid = 1'b1;
        tick_to(131);
        clk_valid = 1'b0;
        tick_to(132);
        clk_valid = 1'b1;
        tick_to(150);
        check("glitch_no_early_rel", 32'(sys_rst), 32'd1);
        check("glitch_retry_kept", 32'(retry_cnt), 32'd1);
        tick_to(151);
        check("glitch_release", 32'(sys_rst), 32'd0);
        check("glitch_locked", 32'(locked_ok), 32'd1);
        check("glitch_retry_clr", 32'(retry_cnt), 32'd0);

        // valid_s rises on the timeout cycle: lock path wins.
        clk_valid = 1'b0;
        apply_reset("pre_tie_to");
        tick_to(101);
        clk_valid = 1'b1;
        tick_to(104);
        check("tie_to_dcm", 32'(dcm_rst), 32'd0);
        check("tie_to_retry", 32'(retry_cnt), 32'd0);
        tick_to(119);
        check("tie_to_pre_rel", 32'(sys_rst), 32'd1);
        tick_to(120);
        check("tie_to_release", 32'(sys_rst), 32'd0);

        // valid_s falls on the stable-limit cycle: no release.
        clk_valid = 1'b0;
        apply_reset("pre_tie_st");
        tick_to(10);
        clk_valid = 1'b1;
        tick_to(26);
        clk_valid = 1'b0;
        tick_to(27);
        clk_valid = 1'b1;
        tick_to(29);
        check("tie_st_no_rel", 32'(sys_rst), 32'd1);
        check("tie_st_locked", 32'(locked_ok), 32'd0);
        check("tie_st_dcm", 32'(dcm_rst), 32'd0);
        tick_to(45);
        check("tie_st_pre_rel", 32'(sys_rst), 32'd1);
        tick_to(46);
        check("tie_st_release", 32'(sys_rst), 32'd0);

        // RESET mid-S_WAIT_LOCK (retry on record) and mid-S_STABLE.
        clk_valid = 1'b0;
        apply_reset("pre_mid");
        tick_to(150);
        check("mid_wait_retry", 32'(retry_cnt), 32'd1);
        apply_reset("mid_wait");
        tick_to(10);
        clk_valid = 1'b1;
        tick_to(20);
        apply_reset("mid_stable");
        tick_to(3);
        check("restart_dcm_hi", 32'(dcm_rst), 32'd1);
        tick_to(4);
        check("restart_dcm_lo", 32'(dcm_rst), 32'd0);
        tick_to(20);
        check("restart_pre_rel", 32'(sys_rst), 32'd1);
        tick_to(21);
        check("restart_release", 32'(sys_rst), 32'd0);
        check("restart_locked", 32'(locked_ok), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
